line_mem_ctrl: RTL and testbench

LINE_MEM_CTRL -- requirements
Module: line_mem_ctrl

---
 rtl/line_mem_ctrl_pkg.sv | 27 ++
 rtl/line_mem_ctrl_register.sv | 20 ++
 rtl/line_mem_ctrl.sv | 120 ++++++++++++
 tb/tb_line_mem_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_ctrl_pkg.sv
// Shared bus types and state encoding for the cache-line memory controller.
package structures;

  localparam int unsigned LINE_BITS = 512;
  localparam int unsigned WORD_BITS = 64;
  localparam int unsigned BEATS     = LINE_BITS / WORD_BITS;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } line_mem_state_t;

  typedef struct packed {
    logic [63:6]          mem_addr;
    logic [LINE_BITS-1:0] mem_data_out;
    logic                 mem_req_load;
    logic                 mem_req_store;
  } mem_bus_req_t;

  typedef struct packed {
    logic [LINE_BITS-1:0] mem_data;
    logic                 mem_ready;
  } mem_bus_resp_t;

endpackage

// File: rtl/line_mem_ctrl_register.sv
// Enable register with asynchronous active-high clear to zero.
module register #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Splits one cache-line load/store into WORD_W-wide beats on a single-outstanding
// memory port and returns the assembled line with a one-cycle ready pulse.
module line_mem_ctrl
  import structures::*;
#(
  parameter int unsigned CACHE_LINE_SIZE = 512,
  parameter int unsigned WORD_W          = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  mem_bus_req_t        req,
  output mem_bus_resp_t       resp,
  output logic [63:0]         mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                mem_re,
  output logic                mem_we,
  input  logic [WORD_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int unsigned NBEATS = CACHE_LINE_SIZE / WORD_W;
  localparam int unsigned KW     = $clog2(NBEATS);
  localparam int unsigned WB     = $clog2(WORD_W / 8);
  localparam int unsigned OFF    = KW + WB;
  localparam int unsigned SW     = $bits(line_mem_state_t);

  logic [SW-1:0]              state_bits_q;
  line_mem_state_t            state_q;
  line_mem_state_t            state_d;
  logic [KW-1:0]              k_q;
  logic [KW-1:0]              k_d;
  logic [63:OFF]              addr_q;
  logic [CACHE_LINE_SIZE-1:0] buf_q;
  logic [CACHE_LINE_SIZE-1:0] buf_d;
  logic                       accept;
  logic                       last_beat;

  assign state_q   = line_mem_state_t'(state_bits_q);
  assign accept    = (state_q == IDLE) && (req.mem_req_load || req.mem_req_store);
  assign last_beat = (k_q == KW'(NBEATS - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        // Store wins when both are requested; the assertion below flags that case.
        if (req.mem_req_store) begin
          state_d = WRITE;
          k_d     = '0;
          buf_d   = req.mem_data_out;
        end else if (req.mem_req_load) begin
          state_d = READ;
          k_d     = '0;
        end
      end
      READ: begin
        if (mem_ack) begin
          buf_d[32'(k_q) * WORD_W +: WORD_W] = mem_rdata;
          k_d = k_q + KW'(1);
          if (last_beat) state_d = RESP;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          k_d = k_q + KW'(1);
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  register #(.WIDTH(SW)) u_state_reg (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (1'b1),
    .d_i   (state_d),
    .q_o   (state_bits_q)
  );

  register #(.WIDTH(KW)) u_beat_reg (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (1'b1),
    .d_i   (k_d),
    .q_o   (k_q)
  );

  register #(.WIDTH(64 - OFF)) u_addr_reg (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (accept),
    .d_i   (req.mem_addr),
    .q_o   (addr_q)
  );

  register #(.WIDTH(CACHE_LINE_SIZE)) u_line_reg (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  (1'b1),
    .d_i   (buf_d),
    .q_o   (buf_q)
  );

  assign mem_re         = (state_q == READ);
  assign mem_we         = (state_q == WRITE);
  assign mem_addr       = (mem_re || mem_we) ? {addr_q, k_q, {WB{1'b0}}} : '0;
  assign mem_wdata      = buf_q[32'(k_q) * WORD_W +: WORD_W];
  assign resp.mem_data  = buf_q;
  assign resp.mem_ready = (state_q == RESP);

  store_load_exclusive: assert property (@(posedge clock) disable iff (reset)
    !((state_q == IDLE) && req.mem_req_load && req.mem_req_store))
    else $fatal(1, "line_mem_ctrl: load and store requested in the same cycle");

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: a word-addressed memory model answers beats, and
// line-level expectations are checked per scenario.
module tb_line_mem_ctrl;
  import structures::*;

  localparam int unsigned LIMIT = 200;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  mem_bus_req_t  req;
  mem_bus_resp_t resp;
  logic [63:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;
  logic          mem_re;
  logic          mem_we;
  logic          mem_ack;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [63:0]  mem_model [logic [63:0]];
  logic [511:0] ref_line  [logic [57:0]];

  int unsigned  obs_rdy_cyc;
  int unsigned  obs_viol;
  logic [511:0] obs_line;
  logic         obs_rdy_after;
  logic         obs_strobe_after;
  logic [63:0]  obs_addr [$];
  logic [63:0]  obs_data [$];

  always #5 clock = ~clock;

  line_mem_ctrl #(.CACHE_LINE_SIZE(512), .WORD_W(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .resp      (resp),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r;
  endfunction

  function automatic logic [57:0] rand58();
    logic [63:0] r;
    r = rand64();
    return r[57:0];
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return mem_model.exists(a) ? mem_model[a] : 64'h0;
  endfunction

  function automatic logic [511:0] line_from_mem(input logic [57:0] l);
    logic [511:0] r;
    for (int unsigned k = 0; k < 8; k++) r[64*k +: 64] = mem_word({l, 6'(8*k)});
    return r;
  endfunction

  task automatic scramble_req();
    int unsigned sel;
    sel = $urandom_range(0, 2);
    req.mem_addr      = rand58();
    req.mem_data_out  = rand_line();
    req.mem_req_load  = (sel == 1);
    req.mem_req_store = (sel == 2);
  endtask

  // Presents one request, answers each beat after `period` strobe cycles, and
  // records what the DUT did; the calling scenario judges the record.
  task automatic do_transfer(input bit st, input logic [57:0] line, input logic [511:0] wl,
                             input int unsigned period, input bit hold, input bit noise);
    int unsigned wcnt;
    wcnt = 0;
    obs_rdy_cyc = 0;
    obs_viol = 0;
    obs_line = '0;
    obs_addr.delete();
    obs_data.delete();
    @(negedge clock);
    req = '0;
    req.mem_addr = line;
    req.mem_data_out = wl;
    req.mem_req_store = st;
    req.mem_req_load = !st;
    for (int unsigned c = 1; c <= LIMIT; c++) begin
      if (c > 1 && !hold) scramble_req();
      mem_ack = 1'b0;
      mem_rdata = rand64();
      if (mem_re && mem_we) obs_viol++;
      if (!mem_re && !mem_we && mem_addr != 64'h0) obs_viol++;
      if (mem_re || mem_we) begin
        if (wcnt == period - 1) begin
          wcnt = 0;
          mem_ack = 1'b1;
          obs_addr.push_back(mem_addr);
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            obs_data.push_back(mem_wdata);
          end else begin
            mem_rdata = mem_word(mem_addr);
            obs_data.push_back(mem_rdata);
          end
        end else begin
          wcnt++;
        end
      end else if (noise) begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (resp.mem_ready === 1'b1) begin
        obs_rdy_cyc = c;
        obs_line = resp.mem_data;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    if (!hold) req = '0;
    mem_ack = 1'b0;
    obs_rdy_after = resp.mem_ready;
    obs_strobe_after = mem_re | mem_we;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    req.mem_req_load = 1'b1;
    req.mem_addr = 58'h3;
    mem_ack = 1'b1;
    mem_rdata = 64'hDEAD;
    #1;
    repeat (3) @(negedge clock);
    n_cmp++; if (mem_re !== 1'b0) begin n_bad++; $display("FAIL reset_re: got %b expected 0", mem_re); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    n_cmp++; if (resp.mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", resp.mem_ready); end
    n_cmp++; if (mem_addr !== 64'h0) begin n_bad++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 64'h0) begin n_bad++; $display("FAIL reset_wdata: got %0h expected 0", mem_wdata); end
    n_cmp++; if (resp.mem_data !== 512'h0) begin n_bad++; $display("FAIL reset_line: got %0h expected 0", resp.mem_data); end
    req = '0;
    mem_ack = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if ((mem_re | mem_we) !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got strobe %b expected 0", mem_re | mem_we); end
  endtask

  task automatic test_read_tied();
    logic [511:0] exp;
    for (int unsigned k = 0; k < 8; k++) begin
      mem_model[64'h400 + 64'(8*k)] = 64'h1000 + 64'(k);
      exp[64*k +: 64] = 64'h1000 + 64'(k);
    end
    do_transfer(1'b0, 58'h10, '0, 1, 1'b0, 1'b0);
    n_cmp++; if (obs_rdy_cyc !== 10) begin n_bad++; $display("FAIL read_latency: got %0d expected 10", obs_rdy_cyc); end
    n_cmp++; if (obs_addr.size() !== 8) begin n_bad++; $display("FAIL read_beats: got %0d expected 8", obs_addr.size()); end
    foreach (obs_addr[k]) begin
      n_cmp++;
      if (obs_addr[k] !== 64'h400 + 64'(8*k)) begin
        n_bad++; $display("FAIL read_addr[%0d]: got %0h expected %0h", k, obs_addr[k], 64'h400 + 64'(8*k));
      end
    end
    n_cmp++; if (obs_line !== exp) begin n_bad++; $display("FAIL read_line: got %0h expected %0h", obs_line, exp); end
    n_cmp++; if (obs_viol !== 0) begin n_bad++; $display("FAIL read_strobes: got %0d violations expected 0", obs_viol); end
    n_cmp++; if (obs_rdy_after !== 1'b0) begin n_bad++; $display("FAIL read_ready_pulse: got %b expected 0", obs_rdy_after); end
    n_cmp++; if (resp.mem_data !== exp) begin n_bad++; $display("FAIL read_line_held: got %0h expected %0h", resp.mem_data, exp); end
  endtask

  task automatic test_store();
    logic [511:0] d;
    int unsigned p;
    for (int unsigned k = 0; k < 8; k++) d[64*k +: 64] = 64'hA5A5_A5A5_A5A5_A500 | 64'(k);
    do_transfer(1'b1, 58'h2, d, 3, 1'b0, 1'b1);
    n_cmp++; if (obs_rdy_cyc !== 26) begin n_bad++; $display("FAIL store_latency: got %0d expected 26", obs_rdy_cyc); end
    n_cmp++; if (obs_addr.size() !== 8) begin n_bad++; $display("FAIL store_beats: got %0d expected 8", obs_addr.size()); end
    foreach (obs_addr[k]) begin
      n_cmp++;
      if (obs_addr[k] !== 64'h80 + 64'(8*k) || obs_data[k] !== d[64*k +: 64]) begin
        n_bad++; $display("FAIL store_beat[%0d]: got %0h/%0h expected %0h/%0h", k, obs_addr[k], obs_data[k], 64'h80 + 64'(8*k), d[64*k +: 64]);
      end
    end
    n_cmp++; if (obs_rdy_after !== 1'b0) begin n_bad++; $display("FAIL store_ready_pulse: got %b expected 0", obs_rdy_after); end
    n_cmp++; if (obs_viol !== 0) begin n_bad++; $display("FAIL store_strobes: got %0d violations expected 0", obs_viol); end
    p = $urandom_range(1, 3);
    do_transfer(1'b0, 58'h2, '0, p, 1'b0, 1'b1);
    n_cmp++; if (obs_line !== d) begin n_bad++; $display("FAIL store_readback: got %0h expected %0h", obs_line, d); end
    n_cmp++; if (obs_rdy_cyc !== 2 + 8*p) begin n_bad++; $display("FAIL readback_latency: got %0d expected %0d", obs_rdy_cyc, 2 + 8*p); end
  endtask

  task automatic test_random();
    logic [57:0]  pool [4];
    logic [511:0] d;
    logic [511:0] exp;
    int unsigned  p;
    int unsigned  i;
    bit           st;
    for (int unsigned n = 0; n < 12; n++) begin
      if (n < 4) pool[n] = rand58();
      i  = (n < 4) ? n : $urandom_range(0, 3);
      st = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      p  = $urandom_range(1, 4);
      d  = rand_line();
      exp = st ? d : ref_line[pool[i]];
      do_transfer(st, pool[i], d, p, 1'b0, 1'b1);
      if (st) ref_line[pool[i]] = d;
      n_cmp++; if (obs_rdy_cyc !== 2 + 8*p) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, obs_rdy_cyc, 2 + 8*p); end
      n_cmp++; if (obs_addr.size() !== 8) begin n_bad++; $display("FAIL rand_beats[%0d]: got %0d expected 8", n, obs_addr.size()); end
      foreach (obs_addr[k]) begin
        n_cmp++;
        if (obs_addr[k] !== {pool[i], 6'(8*k)}) begin
          n_bad++; $display("FAIL rand_addr[%0d.%0d]: got %0h expected %0h", n, k, obs_addr[k], {pool[i], 6'(8*k)});
        end
        if (st) begin
          n_cmp++;
          if (obs_data[k] !== d[64*k +: 64]) begin
            n_bad++; $display("FAIL rand_wdata[%0d.%0d]: got %0h expected %0h", n, k, obs_data[k], d[64*k +: 64]);
          end
        end
      end
      n_cmp++; if (obs_line !== exp) begin n_bad++; $display("FAIL rand_line[%0d]: got %0h expected %0h", n, obs_line, exp); end
      n_cmp++; if (obs_viol !== 0 || obs_rdy_after !== 1'b0) begin n_bad++; $display("FAIL rand_protocol[%0d]: got viol=%0d ready_after=%b expected 0/0", n, obs_viol, obs_rdy_after); end
    end
  endtask

  task automatic test_hold();
    logic [57:0] l;
    bit          seen;
    l = rand58();
    do_transfer(1'b0, l, '0, 1, 1'b1, 1'b0);
    n_cmp++; if (obs_rdy_cyc !== 10) begin n_bad++; $display("FAIL hold_latency: got %0d expected 10", obs_rdy_cyc); end
    n_cmp++; if (obs_strobe_after !== 1'b0) begin n_bad++; $display("FAIL hold_no_resp_accept: got strobe %b expected 0", obs_strobe_after); end
    @(negedge clock);
    n_cmp++; if (mem_re !== 1'b1 || mem_addr !== {l, 6'h0}) begin n_bad++; $display("FAIL hold_reaccept: got re=%b addr=%0h expected 1/%0h", mem_re, mem_addr, {l, 6'h0}); end
    req = '0;
    seen = 1'b0;
    for (int unsigned c = 0; c < 20 && !seen; c++) begin
      mem_ack = mem_re | mem_we;
      mem_rdata = rand64();
      if (resp.mem_ready === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    mem_ack = 1'b0;
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL hold_drain: got ready=%b expected 1", seen); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [57:0] l;
    l = rand58();
    for (int unsigned k = 0; k < 8; k++) mem_model[{l, 6'(8*k)}] = rand64();
    @(negedge clock);
    req = '0;
    req.mem_addr = l;
    req.mem_req_load = 1'b1;
    mem_ack = 1'b0;
    @(negedge clock);
    req = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      mem_ack = 1'b1;
      mem_rdata = rand64();
      @(negedge clock);
    end
    mem_ack = 1'b0;
    n_cmp++; if (mem_re !== 1'b1 || mem_addr !== {l, 6'h20}) begin n_bad++; $display("FAIL mid_beat4: got re=%b addr=%0h expected 1/%0h", mem_re, mem_addr, {l, 6'h20}); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({mem_re, mem_we, resp.mem_ready} !== 3'b000) begin n_bad++; $display("FAIL mid_reset_ctrl: got %b expected 000", {mem_re, mem_we, resp.mem_ready}); end
    n_cmp++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin n_bad++; $display("FAIL mid_reset_bus: got %0h/%0h expected 0/0", mem_addr, mem_wdata); end
    n_cmp++; if (resp.mem_data !== 512'h0) begin n_bad++; $display("FAIL mid_reset_line: got %0h expected 0", resp.mem_data); end
    @(negedge clock);
    n_cmp++; if (resp.mem_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready: got %b expected 0", resp.mem_ready); end
    reset = 1'b0;
    do_transfer(1'b0, l, '0, 1, 1'b0, 1'b0);
    n_cmp++; if (obs_addr.size() == 0 || obs_addr[0] !== {l, 6'h0}) begin n_bad++; $display("FAIL mid_restart_beat0: got %0d beats expected first at %0h", obs_addr.size(), {l, 6'h0}); end
    n_cmp++; if (obs_rdy_cyc !== 10) begin n_bad++; $display("FAIL mid_restart_latency: got %0d expected 10", obs_rdy_cyc); end
    n_cmp++; if (obs_line !== line_from_mem(l)) begin n_bad++; $display("FAIL mid_restart_line: got %0h expected %0h", obs_line, line_from_mem(l)); end
  endtask

  task automatic test_back_to_back();
    logic [57:0]  la;
    logic [57:0]  lb;
    logic [511:0] d1;
    logic [511:0] expb;
    la = rand58();
    lb = rand58();
    d1 = rand_line();
    for (int unsigned k = 0; k < 8; k++) mem_model[{lb, 6'(8*k)}] = rand64();
    expb = line_from_mem(lb);
    do_transfer(1'b1, la, d1, 2, 1'b0, 1'b0);
    n_cmp++; if (obs_rdy_cyc !== 18 || obs_rdy_after !== 1'b0) begin n_bad++; $display("FAIL b2b_cache1_ready: got cyc=%0d after=%b expected 18/0", obs_rdy_cyc, obs_rdy_after); end
    do_transfer(1'b0, lb, '0, 1, 1'b0, 1'b0);
    n_cmp++; if (obs_rdy_cyc !== 10 || obs_line !== expb) begin n_bad++; $display("FAIL b2b_cache2_load: got cyc=%0d line=%0h expected 10/%0h", obs_rdy_cyc, obs_line, expb); end
    do_transfer(1'b0, la, '0, 1, 1'b0, 1'b0);
    n_cmp++; if (obs_line !== d1) begin n_bad++; $display("FAIL b2b_cache1_data: got %0h expected %0h", obs_line, d1); end
  endtask

  initial begin
    req = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_read_tied();
    test_store();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
